// File: rtl/adder_arb_pkg.sv
// Shared types for the adder tree arbiter: FSM states, in-flight job tag and
// grant counter width.
package adder_arb_pkg;

    localparam int CNT_W    = 16;
    localparam int MAX_NREQ = 8;
    localparam int OWNER_W  = $clog2(MAX_NREQ);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } arb_state_e;

    // Owner field is sized for the largest supported requester count so the
    // struct does not depend on the top-level NREQ parameter.
    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } tag_t;

endpackage

// File: rtl/adder_arb_rr_pick.sv
// Combinational round-robin pick: returns a one-hot grant for the first set
// request found searching upward from ptr_i with wrap-around.
module adder_arb_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o
);

    logic [PW:0] idx;
    logic        found;

    // Walk the requesters in priority order starting at the pointer.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_i} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && req_i[idx[PW-1:0]]) begin
                gnt_o[idx[PW-1:0]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_tree_arbiter.sv
// Round-robin arbiter feeding a shared pipelined five-operand adder tree.
// A tag pipe follows each job through the tree so the sum can be returned to
// its owner; a RUN/DRAIN/HALT FSM empties the tree on flush.
// Optional per-requester saturating grant counters: ADDER_ARB_GRANT_CNT_EN.
module adder_tree_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NREQ     = 4,
    parameter int TREE_LAT = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*5*WIDTH-1:0] req_data,
    output logic [WIDTH-1:0]        A,
    output logic [WIDTH-1:0]        B,
    output logic [WIDTH-1:0]        C,
    output logic [WIDTH-1:0]        D,
    output logic [WIDTH-1:0]        E,
    input  logic [WIDTH-1:0]        tree_sum,
    output logic [NREQ-1:0]         resp_valid,
    output logic [WIDTH-1:0]        resp_data,
    input  logic                    flush,
`ifdef ADDER_ARB_GRANT_CNT_EN
    output logic                    halted,
    output logic [NREQ*CNT_W-1:0]   grant_cnt
`else
    output logic                    halted
`endif
);

    localparam int PW  = $clog2(NREQ);
    localparam int OPW = 5 * WIDTH;

    arb_state_e       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [OPW-1:0]   ops_q, ops_d;
    tag_t             tagPipe_q [TREE_LAT+1];
    tag_t             tagIn_d;
    logic [NREQ-1:0]  respValid_q, respValid_d;
    logic [WIDTH-1:0] respData_q, respData_d;

    logic [NREQ-1:0]  pick;
    logic [PW-1:0]    grantIdx;
    logic             grantEn;
    logic             xfer;
    logic             pipeBusy;

    // Grants are suppressed outside RUN and in the very cycle flush appears.
    assign grantEn   = (state_q == ST_RUN) && !flush;
    assign req_ready = grantEn ? pick : '0;
    assign xfer      = |req_ready;

    adder_arb_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // Encode the one-hot pick into the granted requester index.
    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                grantIdx = PW'(i);
            end
        end
    end

    // The pipe is busy while any stage still carries a job.
    always_comb begin
        pipeBusy = 1'b0;
        for (int i = 0; i <= TREE_LAT; i++) begin
            pipeBusy = pipeBusy | tagPipe_q[i].valid;
        end
    end

    // Operand capture, pointer advance, tag injection and response return.
    always_comb begin
        ops_d       = ops_q;
        ptr_d       = ptr_q;
        tagIn_d     = '0;
        respValid_d = '0;
        respData_d  = respData_q;
        if (xfer) begin
            ops_d         = req_data[grantIdx*OPW +: OPW];
            ptr_d         = (grantIdx == PW'(NREQ-1)) ? '0 : grantIdx + 1'b1;
            tagIn_d.valid = 1'b1;
            tagIn_d.owner = OWNER_W'(grantIdx);
        end
        if (tagPipe_q[TREE_LAT].valid) begin
            respValid_d = NREQ'(1) << tagPipe_q[TREE_LAT].owner;
            respData_d  = tree_sum;
        end
    end

    // Flush FSM: stop granting, let in-flight jobs finish, then park in HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!flush)        state_d = ST_RUN;
                else if (!pipeBusy) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!flush) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers; reset drops every in-flight tag so no response escapes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RUN;
            ptr_q       <= '0;
            ops_q       <= '0;
            respValid_q <= '0;
            respData_q  <= '0;
            for (int i = 0; i <= TREE_LAT; i++) begin
                tagPipe_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            ops_q        <= ops_d;
            respValid_q  <= respValid_d;
            respData_q   <= respData_d;
            tagPipe_q[0] <= tagIn_d;
            for (int i = 1; i <= TREE_LAT; i++) begin
                tagPipe_q[i] <= tagPipe_q[i-1];
            end
        end
    end

    assign A          = ops_q[0*WIDTH +: WIDTH];
    assign B          = ops_q[1*WIDTH +: WIDTH];
    assign C          = ops_q[2*WIDTH +: WIDTH];
    assign D          = ops_q[3*WIDTH +: WIDTH];
    assign E          = ops_q[4*WIDTH +: WIDTH];
    assign resp_valid = respValid_q;
    assign resp_data  = respData_q;
    assign halted     = (state_q == ST_HALT);

`ifdef ADDER_ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] cnt_q [NREQ];

    // Per-requester grant counters that stick at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (xfer && (cnt_q[grantIdx] != '1)) begin
            cnt_q[grantIdx] <= cnt_q[grantIdx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : gen_cnt
        assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// Testbench for adder_tree_arbiter: directed scenarios plus random traffic,
// checked every cycle against a job-list reference model.
module tb_adder_tree_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int L     = 1;
    localparam int DW    = NREQ * 5 * WIDTH;

    localparam int MODE_RUN   = 0;
    localparam int MODE_DRAIN = 1;
    localparam int MODE_HALT  = 2;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_ready;
    logic [DW-1:0]    req_data;
    logic [WIDTH-1:0] A, B, C, D, E;
    logic [WIDTH-1:0] tree_sum;
    logic [NREQ-1:0]  resp_valid;
    logic [WIDTH-1:0] resp_data;
    logic             flush;
    logic             halted;
`ifdef ADDER_ARB_GRANT_CNT_EN
    logic [NREQ*16-1:0] grant_cnt;
    int                 cntModel [NREQ];
`endif

    adder_tree_arbiter #(
        .WIDTH    (WIDTH),
        .NREQ     (NREQ),
        .TREE_LAT (L)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .E          (E),
        .tree_sum   (tree_sum),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .flush      (flush),
`ifdef ADDER_ARB_GRANT_CNT_EN
        .halted     (halted),
        .grant_cnt  (grant_cnt)
`else
        .halted     (halted)
`endif
    );

    always #5 CLK = ~CLK;

    // Behavioural adder tree: sum of the presented operands, L cycles later.
    logic [WIDTH-1:0] treePipe [L];
    always @(posedge CLK) begin
        treePipe[0] <= A + B + C + D + E;
        for (int i = 1; i < L; i++) treePipe[i] <= treePipe[i-1];
    end
    assign tree_sum = treePipe[L-1];

    typedef struct {
        int               owner;
        int               g;
        logic [WIDTH-1:0] sum;
    } job_t;

    job_t             jobs[$];
    int               cyc      = 0;
    int               rrNext   = 0;
    int               mode     = MODE_RUN;
    logic [5*WIDTH-1:0] lastOps  = '0;
    logic [WIDTH-1:0] lastResp = '0;
    int               checks   = 0;
    int               errors   = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [DW-1:0] d,
                                 input logic f, input logic r);
        @(posedge CLK);
        #1;
        req_valid = v;
        req_data  = d;
        flush     = f;
        RST       = r;
    endtask

    function automatic logic [DW-1:0] packOps(input int idx, input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] e);
        logic [DW-1:0] v;
        v = '0;
        v[idx*5*WIDTH +: 5*WIDTH] = {e, d, c, b, a};
        return v;
    endfunction

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] v;
        for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: evaluated mid-cycle once inputs have settled.
    always @(negedge CLK) begin : model
        int              gi;
        int              s;
        bit              busy;
        logic [NREQ-1:0] expReady;
        logic [NREQ-1:0] expRv;
        logic [WIDTH-1:0] expRd;
        gi       = -1;
        expReady = '0;
        if (mode == MODE_RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
                if (gi < 0 && req_valid[(rrNext + k) % NREQ]) gi = (rrNext + k) % NREQ;
            end
        end
        if (gi >= 0) expReady[gi] = 1'b1;
        expRv = '0;
        expRd = lastResp;
        foreach (jobs[q]) begin
            if (jobs[q].g + L + 2 == cyc) begin
                expRv[jobs[q].owner] = 1'b1;
                expRd = jobs[q].sum;
            end
        end
        checkOutput("ready", 64'(req_ready), 64'(expReady));
        checkOutput("respValid", 64'(resp_valid), 64'(expRv));
        checkOutput("respData", 64'(resp_data), 64'(expRd));
        checkOutput("halted", 64'(halted), 64'(mode == MODE_HALT));
        checkOutput("opA", 64'(A), 64'(lastOps[0*WIDTH +: WIDTH]));
        checkOutput("opB", 64'(B), 64'(lastOps[1*WIDTH +: WIDTH]));
        checkOutput("opC", 64'(C), 64'(lastOps[2*WIDTH +: WIDTH]));
        checkOutput("opD", 64'(D), 64'(lastOps[3*WIDTH +: WIDTH]));
        checkOutput("opE", 64'(E), 64'(lastOps[4*WIDTH +: WIDTH]));
`ifdef ADDER_ARB_GRANT_CNT_EN
        for (int i = 0; i < NREQ; i++) checkOutput("grantCnt", 64'(grant_cnt[i*16 +: 16]), 64'(cntModel[i]));
`endif
        if (RST) begin
            jobs.delete();
            rrNext   = 0;
            mode     = MODE_RUN;
            lastOps  = '0;
            lastResp = '0;
`ifdef ADDER_ARB_GRANT_CNT_EN
            for (int i = 0; i < NREQ; i++) cntModel[i] = 0;
`endif
        end else begin
            busy = 1'b0;
            foreach (jobs[q]) if (cyc >= jobs[q].g + 1 && cyc <= jobs[q].g + 1 + L) busy = 1'b1;
            if (expRv != '0) lastResp = expRd;
            if (gi >= 0) begin
                s = 0;
                for (int op = 0; op < 5; op++) s += int'(req_data[gi*5*WIDTH + op*WIDTH +: WIDTH]);
                jobs.push_back('{owner: gi, g: cyc, sum: WIDTH'(s)});
                lastOps = req_data[gi*5*WIDTH +: 5*WIDTH];
                rrNext  = (gi + 1) % NREQ;
`ifdef ADDER_ARB_GRANT_CNT_EN
                if (cntModel[gi] < 65535) cntModel[gi]++;
`endif
            end
            case (mode)
                MODE_RUN:   if (flush) mode = MODE_DRAIN;
                MODE_DRAIN: if (!flush) mode = MODE_RUN; else if (!busy) mode = MODE_HALT;
                default:    if (!flush) mode = MODE_RUN;
            endcase
            while (jobs.size() > 0 && jobs[0].g + L + 2 <= cyc) void'(jobs.pop_front());
        end
        cyc++;
    end

    logic [DW-1:0] d;
    logic          fl;

    initial begin
        RST       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
`ifdef ADDER_ARB_GRANT_CNT_EN
        for (int i = 0; i < NREQ; i++) cntModel[i] = 0;
`endif
        applyStimulus('0, '0, 1'b0, 1'b1);
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0);

        // Single job from requester 2.
        d = packOps(2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
        applyStimulus(4'b0100, d, 1'b0, 1'b0);
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("singleValid", 64'(resp_valid), 64'h4);
        checkOutput("singleData", 64'(resp_data), 64'd15);
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0);

        // Round robin with all requesters active from a fresh pointer.
        applyStimulus('0, '0, 1'b0, 1'b1);
        d = '0;
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 5; k++) d[i*5*WIDTH + k*WIDTH +: WIDTH] = WIDTH'(i*5 + k + 1);
        repeat (8) applyStimulus('1, d, 1'b0, 1'b0);
        repeat (4) applyStimulus('0, '0, 1'b0, 1'b0);

        // Modulo wrap of the sum.
        d = packOps(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        applyStimulus(4'b0001, d, 1'b0, 1'b0);
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("wrapValid", 64'(resp_valid), 64'h1);
        checkOutput("wrapData", 64'(resp_data), 64'hFFFB);

        // Flush with two jobs in flight, then resume.
        d = randData();
        applyStimulus(4'b0010, d, 1'b0, 1'b0);
        applyStimulus(4'b1000, d, 1'b0, 1'b0);
        repeat (6) applyStimulus('1, d, 1'b1, 1'b0);
        checkOutput("flushHalted", 64'(halted), 64'd1);
        repeat (3) applyStimulus('1, d, 1'b0, 1'b0);
        repeat (4) applyStimulus('0, '0, 1'b0, 1'b0);

        // Reset while a job is in flight.
        applyStimulus(4'b0100, d, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0);
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("rstNoResp", 64'(resp_valid), 64'd0);
        repeat (2) applyStimulus('0, '0, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset.
        fl = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) fl = ~fl;
            applyStimulus(NREQ'($urandom), randData(), fl, $urandom_range(0, 63) == 0);
        end
        repeat (6) applyStimulus('0, '0, 1'b0, 1'b0);

`ifdef ADDER_ARB_GRANT_CNT_EN
        // Saturating counter for requester 1.
        applyStimulus('0, '0, 1'b0, 1'b1);
        d = randData();
        repeat (70000) applyStimulus(4'b0010, d, 1'b0, 1'b0);
        repeat (3) applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("cntSat", 64'(grant_cnt[31:16]), 64'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
